pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS pipeline. It generates the PC/IF_ID write enables, the IF_ID flush and the ID_EX bubble, which forces a NOP into ID_EX by zeroing its control inputs and setting `IF_ID_IS_NOP`. It also produces an EX hold for multi-cycle mult/div. It resolves load-use hazards, branch/jump redirects, EX-stage exceptions and mult/div occupancy from signals the ID and EX stages already carry.

## Interface
- `MD_LATENCY`, 32, total EX cycles a mult/div occupies (≥2)
- `CNT_W`, 6, counter width (2^CNT_W > MD_LATENCY)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `id_rs`, `id_rt`  in  5 each  source register fields of the instruction in ID
- `id_use_rs`, `id_use_rt`  in  1 each  ID instruction reads rs / rt
- `ex_MemRead`  in  3  ID_EX `MemRead_out`; nonzero = load in EX
- `ex_rt`  in  5  ID_EX `rt_out`
- `ex_branch_taken`  in  1  branch in EX resolved taken
- `ex_jump`  in  1  jump in EX
- `ex_md_start`  in  1  mult/div instruction present in EX
- `ex_exc`  in  1  EX instruction carries nonzero EXCCODE
- `PC_write`  out  1  PC register enable
- `IF_ID_write`  out  1  IF_ID enable
- `IF_ID_flush`  out  1  IF_ID loads NOP
- `ID_EX_bubble`  out  1  ID_EX loads NOP
- `EX_stall`  out  1  hold ID_EX and EX stage contents
- `md_done`  out  1  one-cycle pulse: mult/div result valid for EX write
- `exc_ack`  out  1  one-cycle pulse: exception taken
- `state`  out  2  RUN=0, MD_BUSY=1, MD_DONE=2, EXC=3

## Operation
- State register `state` and down-counter `cnt[CNT_W-1:0]` are registered. All other outputs are combinational from `state`, `cnt` and the inputs.
- Default outputs are `PC_write=1`, `IF_ID_write=1`, and 0 for all others.
- Hazard `lu` = (`ex_MemRead`≠0) & (`ex_rt`≠0) & ((`id_use_rs` & `id_rs`==`ex_rt`) | (`id_use_rt` & `id_rt`==`ex_rt`)).
- RUN and MD_DONE share the same event handling. The one exception is that `ex_md_start` is ignored in MD_DONE. Events are evaluated in strict priority order:
  1. `ex_exc`: `PC_write=1` (PC loads the vector), `IF_ID_flush=1`, `ID_EX_bubble=1`. Next state is EXC.
  2. `ex_branch_taken` | `ex_jump`: `PC_write=1`, `IF_ID_flush=1`, `ID_EX_bubble=1`. Next state is RUN. A simultaneous `lu` is discarded.
  3. `ex_md_start` (RUN only): `PC_write=0`, `IF_ID_write=0`, `EX_stall=1`. Next, `cnt`←MD_LATENCY−1 and state becomes MD_BUSY.
  4. `lu`: `PC_write=0`, `IF_ID_write=0`, `ID_EX_bubble=1`. Next state is RUN. The bubble clears `ex_MemRead`, so the stall lasts exactly 1 cycle.
- MD_BUSY:
  - Outputs: `PC_write=0`, `IF_ID_write=0`, `EX_stall=1`.
  - `cnt` decrements each cycle. When `cnt`==1, next state is MD_DONE.
  - `ex_exc`, `ex_branch_taken`, `ex_jump` and `lu` are ignored.
- MD_DONE:
  - `md_done=1` and `EX_stall=0`; the mult/div leaves EX at the end of this cycle.
  - Event handling follows the RUN priority list minus item 3. Next state is RUN unless item 1 fires.
- EXC:
  - Outputs: `exc_ack=1`, `PC_write=0`, `IF_ID_write=0`, `IF_ID_flush=1`, `ID_EX_bubble=1`.
  - Next state is RUN unconditionally.
- Counter arithmetic is unsigned and never decrements below 1 in MD_BUSY. `cnt` is a don't-care outside MD_BUSY and is held.

## Timing
- Reset: while `rst`=1, outputs are forced to `PC_write=0`, `IF_ID_write=0`, `IF_ID_flush=1`, `ID_EX_bubble=1`, `EX_stall=0`, `md_done=0`, `exc_ack=0`.
- After the reset edge: `state`=RUN and `cnt`=0.
- A reset asserted in MD_BUSY or EXC aborts the sequence and returns to RUN on that edge.
- Load-use costs 1 bubble cycle. A branch/jump costs 2 squashed slots (IF_ID and ID_EX) in the same cycle.
- Mult/div holds EX for exactly MD_LATENCY cycles: the start cycle plus MD_LATENCY−1 MD_BUSY cycles. MD_DONE follows with no stall.
- An exception costs 2 cycles: the trigger cycle plus EXC. The fetch resumes at the vector in the cycle after EXC.
- `md_done` and `exc_ack` are never high for more than 1 consecutive cycle.

## Test plan
- Reset with all inputs 0 → `state`=0, `PC_write`=1 and `IF_ID_write`=1 on the first cycle after reset.
- `ex_MemRead`=3'b001, `ex_rt`=5, `id_rs`=5, `id_use_rs`=1 → same cycle `PC_write`=0, `IF_ID_write`=0, `ID_EX_bubble`=1. Repeat with `ex_rt`=0 → no stall.
- Same load-use as above plus `ex_branch_taken`=1 → `IF_ID_flush`=1, `ID_EX_bubble`=1, `PC_write`=1.
- With MD_LATENCY=4, pulse `ex_md_start` at t0 and hold it high → `EX_stall`=1 for t0–t3, `md_done`=1 at t4 only, `state` returns to 0 at t5. An `ex_exc` raised at t2 is ignored.
- `ex_exc`=1 at t0 → t0 flush+bubble with `PC_write`=1, t1 `exc_ack`=1 and `state`=3, t2 `state`=0.
- Assert `rst` at t2 of a mult/div → at t3 `state`=0 and `EX_stall`=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the sequencing
// controller (slave): ID/EX hazard sources in, stage enables/flushes/holds out.
interface pipe_hazard_ctrl_if;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_use_rs;
   logic       id_use_rt;
   logic [2:0] ex_MemRead;
   logic [4:0] ex_rt;
   logic       ex_branch_taken;
   logic       ex_jump;
   logic       ex_md_start;
   logic       ex_exc;
   logic       PC_write;
   logic       IF_ID_write;
   logic       IF_ID_flush;
   logic       ID_EX_bubble;
   logic       EX_stall;
   logic       md_done;
   logic       exc_ack;
   logic [1:0] state;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, ex_MemRead, ex_rt,
             ex_branch_taken, ex_jump, ex_md_start, ex_exc,
      input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_stall,
             md_done, exc_ack, state
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, ex_MemRead, ex_rt,
             ex_branch_taken, ex_jump, ex_md_start, ex_exc,
      output PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_stall,
             md_done, exc_ack, state
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing controller: load-use stalls, branch/jump squashes,
// EX exceptions and multi-cycle mult/div occupancy of the EX stage.
module pipe_hazard_ctrl #(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_hazard_ctrl_if.slave    hz
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MD_BUSY = 2'd1,
      ST_MD_DONE = 2'd2,
      ST_EXC     = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MD_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_r;
   state_t           state_nx_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nx_s;
   logic             lu_s;
   logic             pc_write_s;
   logic             if_id_write_s;
   logic             if_id_flush_s;
   logic             id_ex_bubble_s;
   logic             ex_stall_s;
   logic             md_done_s;
   logic             exc_ack_s;

   // Load in EX whose destination feeds a source the ID instruction actually reads.
   assign lu_s = (hz.ex_MemRead != 3'd0) && (hz.ex_rt != 5'd0) &&
                 ((hz.id_use_rs && (hz.id_rs == hz.ex_rt)) ||
                  (hz.id_use_rt && (hz.id_rt == hz.ex_rt)));

   // State and mult/div countdown register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_RUN;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Next-state and stage-control decode.
   always_comb begin
      pc_write_s     = 1'b1;
      if_id_write_s  = 1'b1;
      if_id_flush_s  = 1'b0;
      id_ex_bubble_s = 1'b0;
      ex_stall_s     = 1'b0;
      md_done_s      = 1'b0;
      exc_ack_s      = 1'b0;
      state_nx_s     = state_r;
      cnt_nx_s       = cnt_r;
      if (rst) begin
         pc_write_s     = 1'b0;
         if_id_write_s  = 1'b0;
         if_id_flush_s  = 1'b1;
         id_ex_bubble_s = 1'b1;
         state_nx_s     = ST_RUN;
         cnt_nx_s       = '0;
      end else begin
         case (state_r)
            ST_RUN, ST_MD_DONE: begin
               md_done_s  = (state_r == ST_MD_DONE);
               state_nx_s = ST_RUN;
               // A mult/div just finishing cannot launch another from the same EX slot.
               if (hz.ex_exc) begin
                  if_id_flush_s  = 1'b1;
                  id_ex_bubble_s = 1'b1;
                  state_nx_s     = ST_EXC;
               end else if (hz.ex_branch_taken || hz.ex_jump) begin
                  if_id_flush_s  = 1'b1;
                  id_ex_bubble_s = 1'b1;
               end else if (hz.ex_md_start && (state_r == ST_RUN)) begin
                  pc_write_s    = 1'b0;
                  if_id_write_s = 1'b0;
                  ex_stall_s    = 1'b1;
                  cnt_nx_s      = CNT_START;
                  state_nx_s    = ST_MD_BUSY;
               end else if (lu_s) begin
                  pc_write_s     = 1'b0;
                  if_id_write_s  = 1'b0;
                  id_ex_bubble_s = 1'b1;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end
            ST_MD_BUSY: begin
               pc_write_s    = 1'b0;
               if_id_write_s = 1'b0;
               ex_stall_s    = 1'b1;
               if (cnt_r > CNT_ONE) begin
                  cnt_nx_s   = cnt_r - CNT_ONE;
                  state_nx_s = ST_MD_BUSY;
               end else begin
                  state_nx_s = ST_MD_DONE;
               end
            end
            ST_EXC: begin
               exc_ack_s      = 1'b1;
               pc_write_s     = 1'b0;
               if_id_write_s  = 1'b0;
               if_id_flush_s  = 1'b1;
               id_ex_bubble_s = 1'b1;
               state_nx_s     = ST_RUN;
            end
            default: begin
               state_nx_s = ST_RUN;
            end
         endcase
      end
   end

   assign hz.PC_write     = pc_write_s;
   assign hz.IF_ID_write  = if_id_write_s;
   assign hz.IF_ID_flush  = if_id_flush_s;
   assign hz.ID_EX_bubble = id_ex_bubble_s;
   assign hz.EX_stall     = ex_stall_s;
   assign hz.md_done      = md_done_s;
   assign hz.exc_ack      = exc_ack_s;
   assign hz.state        = state_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MD_LATENCY=4: reset, load-use, squashes,
// mult/div occupancy, exceptions and mid-sequence resets.
module tb_pipe_hazard_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
      hz.ex_MemRead = 3'd0; hz.ex_rt = 5'd0; hz.ex_branch_taken = 1'b0;
      hz.ex_jump = 1'b0; hz.ex_md_start = 1'b0; hz.ex_exc = 1'b0;
   endtask

   // Packed {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_stall, md_done, exc_ack}
   function automatic logic [31:0] ctl();
      return {25'd0, hz.PC_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_bubble,
              hz.EX_stall, hz.md_done, hz.exc_ack};
   endfunction

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      clear_inputs();

      tick();
      chk("reset_forced_ctl", ctl(), 32'b0011000);
      tick();
      rst = 1'b0;
      #1;
      chk("post_reset_state", {30'd0, hz.state}, 32'd0);
      chk("post_reset_ctl", ctl(), 32'b1100000);

      // Load-use on rs
      hz.ex_MemRead = 3'b001; hz.ex_rt = 5'd5; hz.id_rs = 5'd5; hz.id_use_rs = 1'b1;
      #1;
      chk("lu_rs_ctl", ctl(), 32'b0001000);
      tick();
      chk("lu_rs_state", {30'd0, hz.state}, 32'd0);
      hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
      #1;
      chk("lu_r0_no_stall", ctl(), 32'b1100000);

      // Load-use on rt, then same registers with the read flag off
      hz.ex_MemRead = 3'b100; hz.ex_rt = 5'd7; hz.id_rt = 5'd7;
      hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b1;
      #1;
      chk("lu_rt_ctl", ctl(), 32'b0001000);
      hz.id_use_rt = 1'b0;
      #1;
      chk("lu_rt_unused", ctl(), 32'b1100000);
      hz.ex_MemRead = 3'b000; hz.id_use_rt = 1'b1;
      #1;
      chk("lu_no_load", ctl(), 32'b1100000);

      // Branch overrides load-use; jump alone
      clear_inputs();
      hz.ex_MemRead = 3'b001; hz.ex_rt = 5'd5; hz.id_rs = 5'd5; hz.id_use_rs = 1'b1;
      hz.ex_branch_taken = 1'b1;
      #1;
      chk("branch_over_lu", ctl(), 32'b1111000);
      tick();
      chk("branch_state", {30'd0, hz.state}, 32'd0);
      clear_inputs();
      hz.ex_jump = 1'b1;
      #1;
      chk("jump_ctl", ctl(), 32'b1111000);
      tick();
      clear_inputs();

      // Mult/div: start at t0 held high, exception raised at t2 is ignored
      hz.ex_md_start = 1'b1;
      #1;
      chk("md_t0_ctl", ctl(), 32'b0000100);
      chk("md_t0_state", {30'd0, hz.state}, 32'd0);
      tick();
      chk("md_t1_state", {30'd0, hz.state}, 32'd1);
      chk("md_t1_ctl", ctl(), 32'b0000100);
      tick();
      hz.ex_exc = 1'b1;
      #1;
      chk("md_t2_exc_ignored", ctl(), 32'b0000100);
      tick();
      hz.ex_exc = 1'b0;
      chk("md_t3_state", {30'd0, hz.state}, 32'd1);
      chk("md_t3_ctl", ctl(), 32'b0000100);
      tick();
      chk("md_t4_state", {30'd0, hz.state}, 32'd2);
      chk("md_t4_ctl", ctl(), 32'b1100010);
      tick();
      chk("md_t5_state", {30'd0, hz.state}, 32'd0);
      hz.ex_md_start = 1'b0;
      #1;
      chk("md_t5_ctl", ctl(), 32'b1100000);

      // Exception: trigger cycle, EXC, back to RUN
      tick();
      hz.ex_exc = 1'b1;
      #1;
      chk("exc_t0_ctl", ctl(), 32'b1111000);
      tick();
      hz.ex_exc = 1'b0;
      chk("exc_t1_state", {30'd0, hz.state}, 32'd3);
      chk("exc_t1_ctl", ctl(), 32'b0011001);
      tick();
      chk("exc_t2_state", {30'd0, hz.state}, 32'd0);
      chk("exc_t2_ctl", ctl(), 32'b1100000);

      // Exception arriving in MD_DONE takes priority over the return to RUN
      hz.ex_md_start = 1'b1;
      tick();
      hz.ex_md_start = 1'b0;
      tick();
      tick();
      tick();
      chk("mdexc_state_done", {30'd0, hz.state}, 32'd2);
      hz.ex_exc = 1'b1;
      #1;
      chk("mdexc_done_ctl", ctl(), 32'b1111010);
      tick();
      hz.ex_exc = 1'b0;
      chk("mdexc_to_exc", {30'd0, hz.state}, 32'd3);
      tick();
      chk("mdexc_back_run", {30'd0, hz.state}, 32'd0);

      // Reset at t2 of a mult/div
      hz.ex_md_start = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rst_md_forced_ctl", ctl(), 32'b0011000);
      tick();
      rst = 1'b0;
      hz.ex_md_start = 1'b0;
      #1;
      chk("rst_md_t3_state", {30'd0, hz.state}, 32'd0);
      chk("rst_md_t3_stall", {31'd0, hz.EX_stall}, 32'd0);

      // Reset while in EXC
      hz.ex_exc = 1'b1;
      tick();
      hz.ex_exc = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_exc_state", {30'd0, hz.state}, 32'd0);
      chk("rst_exc_ack", {31'd0, hz.exc_ack}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
